// File: rtl/dmem_port_arbiter_pkg.sv
// Shared DMEM access definitions: funct3 codes, FSM states, latched request record
// and the funct3 legality rule used by the arbiter front end.
package dmem_port_arbiter_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way arbiter for the DMEM port: CPU-priority with port-1 starvation guard, or
// round-robin. Grant is combinational; history updates only on arb_en.
module dmem_rr_arb2
  import dmem_port_arbiter_pkg::*;
#(
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic [1:0] grant,
  output logic       grant_id
);

  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] MAX_W = WW'(MAX_WAIT);

  logic          r_last_grant;
  logic [WW-1:0] r_wait_cnt;
  logic          w_pick1;
  logic          w_take;

  always_comb begin
    w_pick1 = 1'b0;
    case (req)
      2'b10: w_pick1 = 1'b1;
      2'b11: begin
        if (CPU_PRIORITY != 0)
          w_pick1 = (r_wait_cnt == MAX_W);
        else
          w_pick1 = ~r_last_grant;
      end
      default: w_pick1 = 1'b0;
    endcase
  end

  assign w_take   = arb_en & (|req);
  assign grant_id = w_pick1;
  assign grant    = w_take ? (w_pick1 ? 2'b10 : 2'b01) : 2'b00;

  // wait_cnt counts only real losses: port 1 asking while port 0 is granted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
    end else if (w_take) begin
      r_last_grant <= w_pick1;
      if (w_pick1)
        r_wait_cnt <= '0;
      else if (req[1] && (r_wait_cnt != MAX_W))
        r_wait_cnt <= r_wait_cnt + WW'(1);
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one DMEM between CPU (port 0) and DMA (port 1): IDLE -> ACCESS -> RESP, ack at G+2
// (G+1 on reject). Requesters hold req until ack; req is ignored while busy.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WORDS        = 1024,
  parameter int CPU_PRIORITY = 1,
  parameter int MAX_WAIT     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_funct3,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_funct3,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_MemRead,
  output logic        mem_MemWrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        grant_id
);

  state_t      r_state;
  state_t      w_next_state;
  dmem_req_t   r_req;
  dmem_req_t   w_sel;
  logic        r_grant_id;
  logic        r_err;
  logic [31:0] r_rdata;
  logic        w_arb_en;
  logic [1:0]  w_grant;
  logic        w_grant_id;
  logic        w_legal;
  logic        w_access;
  logic        w_resp;

  assign w_arb_en = (r_state == ST_IDLE);

  dmem_rr_arb2 #(
    .CPU_PRIORITY (CPU_PRIORITY),
    .MAX_WAIT     (MAX_WAIT)
  ) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      ({p1_req, p0_req}),
    .arb_en   (w_arb_en),
    .grant    (w_grant),
    .grant_id (w_grant_id)
  );

  always_comb begin
    w_sel = '{we: p0_we, addr: p0_addr, wdata: p0_wdata, funct3: p0_funct3};
    if (w_grant[1])
      w_sel = '{we: p1_we, addr: p1_addr, wdata: p1_wdata, funct3: p1_funct3};
  end

  assign w_legal = funct3_legal(w_sel.we, w_sel.funct3) && (w_sel.addr < 32'(WORDS));

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (|w_grant) w_next_state = w_legal ? ST_ACCESS : ST_RESP;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // rdata is cleared at grant so stores and rejects answer with zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_req      <= '0;
      r_grant_id <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else if ((r_state == ST_IDLE) && (|w_grant)) begin
      r_req      <= w_sel;
      r_grant_id <= w_grant_id;
      r_err      <= ~w_legal;
      r_rdata    <= '0;
    end else if ((r_state == ST_ACCESS) && !r_req.we) begin
      r_rdata    <= mem_read_data;
    end
  end

  // Reset gating keeps a reset cycle from committing a store or emitting an ack
  assign w_access = (r_state == ST_ACCESS) & ~reset;
  assign w_resp   = (r_state == ST_RESP) & ~reset;

  assign mem_MemRead    = w_access & ~r_req.we;
  assign mem_MemWrite   = w_access & r_req.we;
  assign mem_address    = w_access ? r_req.addr   : 32'd0;
  assign mem_write_data = w_access ? r_req.wdata  : 32'd0;
  assign mem_funct3     = w_access ? r_req.funct3 : 3'd0;

  assign p0_ack   = w_resp & ~r_grant_id;
  assign p1_ack   = w_resp & r_grant_id;
  assign p0_err   = p0_ack & r_err;
  assign p1_err   = p1_ack & r_err;
  assign p0_rdata = p0_ack ? r_rdata : 32'd0;
  assign p1_rdata = p1_ack ? r_rdata : 32'd0;

  assign busy     = (r_state != ST_IDLE) & ~reset;
  assign grant_id = r_grant_id & ~reset;

endmodule
